// File: rtl/riscv_apu_arbiter.sv
// Round-robin arbiter sharing one APU between several cores.
// Tracks outstanding requests in an ID FIFO so in-order results are routed back to their issuer.
module riscv_apu_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int WOP       = 96,
  parameter int WRES      = 32,
  parameter int DEPTH     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CORES-1:0]           core_req_i,
  input  logic [NUM_CORES-1:0][WOP-1:0]  core_operands_i,
  output logic [NUM_CORES-1:0]           core_gnt_o,
  output logic [NUM_CORES-1:0]           core_valid_o,
  output logic [WRES-1:0]                core_result_o,
  output logic                           apu_req_o,
  output logic [WOP-1:0]                 apu_operands_o,
  input  logic                           apu_gnt_i,
  input  logic                           apu_valid_i,
  input  logic [WRES-1:0]                apu_result_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int CW = $clog2(NUM_CORES);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_fifo [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [NW-1:0] r_count;
  logic          r_err;

  logic [CW-1:0] w_win;
  logic [CW-1:0] w_idx;
  logic          w_found;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] incPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // First requester at or after r_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_idx = CW'((int'(r_ptr) + i) % NUM_CORES);
      if (!w_found && core_req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == NW'(DEPTH));
  assign apu_req_o = rst_ni & (|core_req_i) & ~w_full;
  assign w_accept  = apu_req_o & apu_gnt_i;
  assign w_bypass  = w_empty & apu_valid_i & w_accept;
  assign w_push    = w_accept & ~w_bypass;
  assign w_pop     = apu_valid_i & ~w_empty;

  assign busy_o        = ~w_empty;
  assign err_o         = r_err;
  assign core_result_o = apu_result_i;

  always_comb begin
    core_gnt_o     = '0;
    core_valid_o   = '0;
    apu_operands_o = '0;
    if (apu_req_o) begin
      apu_operands_o = core_operands_i[w_win];
    end
    if (w_accept) begin
      core_gnt_o[w_win] = 1'b1;
    end
    if (w_bypass) begin
      core_valid_o[w_win] = 1'b1;
    end else if (w_pop) begin
      core_valid_o[r_fifo[r_rdPtr]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr   <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr <= (w_win == CW'(NUM_CORES - 1)) ? '0 : w_win + CW'(1);
      end
      if (w_push) begin
        r_wrPtr <= incPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= incPtr(r_rdPtr);
      end
      r_count <= r_count + NW'(w_push) - NW'(w_pop);
      // A result with nothing outstanding and no same-cycle bypass has no owner.
      if (apu_valid_i && w_empty && !w_accept) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read while r_count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= w_win;
    end
  end

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Randomized scoreboard bench for riscv_apu_arbiter.
// The driver plays cores and APU from a queue-based reference model; a monitor checks every response strobe.
module tb_riscv_apu_arbiter;

  localparam int N     = 4;
  localparam int WOP   = 96;
  localparam int WRES  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    int              id;
    logic [WRES-1:0] res;
  } sbEntry_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          core_req_i;
  logic [N-1:0][WOP-1:0] core_operands_i;
  logic [N-1:0]          core_gnt_o;
  logic [N-1:0]          core_valid_o;
  logic [WRES-1:0]       core_result_o;
  logic                  apu_req_o;
  logic [WOP-1:0]        apu_operands_o;
  logic                  apu_gnt_i;
  logic                  apu_valid_i;
  logic [WRES-1:0]       apu_result_i;
  logic                  busy_o;
  logic                  err_o;

  int nChecks = 0;
  int nFail   = 0;

  int              mPtr;
  bit              mErr;
  int              mIds[$];
  logic [WRES-1:0] resQ[$];
  sbEntry_t        sb[$];
  logic [N-1:0]    pendReq;
  logic [WOP-1:0]  ops[N];

  always #5 clk = ~clk;

  riscv_apu_arbiter #(
    .NUM_CORES(N), .WOP(WOP), .WRES(WRES), .DEPTH(DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_req_i     (core_req_i),
    .core_operands_i(core_operands_i),
    .core_gnt_o     (core_gnt_o),
    .core_valid_o   (core_valid_o),
    .core_result_o  (core_result_o),
    .apu_req_o      (apu_req_o),
    .apu_operands_o (apu_operands_o),
    .apu_gnt_i      (apu_gnt_i),
    .apu_valid_i    (apu_valid_i),
    .apu_result_i   (apu_result_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  function automatic logic [WRES-1:0] apuCalc(input logic [WOP-1:0] o);
    return (o[31:0] + o[63:32]) ^ o[95:64];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: cores raise new requests, the APU grants/answers, outputs are checked against the model.
  task automatic applyStimulus(input logic [N-1:0] newReq, input logic gnt,
                               input logic wantValid, input logic allowSpurious);
    int              expWin;
    bit              expReq, expAcc, bypass, spurious, valid, popped;
    logic [WRES-1:0] res;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pendReq[i] && newReq[i]) begin
        pendReq[i] = 1'b1;
        ops[i] = {$urandom, $urandom, $urandom};
      end
      core_operands_i[i] = ops[i];
    end
    core_req_i = pendReq;
    apu_gnt_i  = gnt;
    expWin = -1;
    for (int k = 0; k < N; k++) begin
      if (expWin < 0 && pendReq[(mPtr + k) % N]) expWin = (mPtr + k) % N;
    end
    expReq   = (expWin >= 0) && (mIds.size() != DEPTH);
    expAcc   = expReq && gnt;
    bypass   = 1'b0;
    spurious = 1'b0;
    valid    = 1'b0;
    popped   = 1'b0;
    res      = $urandom;
    if (wantValid) begin
      if (mIds.size() != 0) begin
        valid  = 1'b1;
        popped = 1'b1;
        res    = resQ.pop_front();
      end else if (expAcc) begin
        valid  = 1'b1;
        bypass = 1'b1;
        res    = apuCalc(ops[expWin]);
      end
    end else if (allowSpurious && mIds.size() == 0 && !expAcc) begin
      valid    = 1'b1;
      spurious = 1'b1;
    end
    apu_valid_i  = valid;
    apu_result_i = res;
    #1;
    checkOutput("apu_req", 128'(apu_req_o), 128'(expReq));
    checkOutput("core_gnt", 128'(core_gnt_o), expAcc ? 128'(N'(1) << expWin) : 128'(0));
    checkOutput("apu_operands", 128'(apu_operands_o), expReq ? 128'(ops[expWin]) : 128'(0));
    checkOutput("busy", 128'(busy_o), 128'(mIds.size() != 0));
    checkOutput("err", 128'(err_o), 128'(mErr));
    checkOutput("core_result", 128'(core_result_o), 128'(res));
    if (popped) void'(mIds.pop_front());
    if (spurious) mErr = 1'b1;
    if (expAcc) begin
      sb.push_back('{id: expWin, res: apuCalc(ops[expWin])});
      if (!bypass) begin
        mIds.push_back(expWin);
        resQ.push_back(apuCalc(ops[expWin]));
      end
      pendReq[expWin] = 1'b0;
      mPtr = (expWin + 1) % N;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n       = 1'b0;
    apu_gnt_i   = 1'b0;
    apu_valid_i = 1'b1;
    core_req_i  = pendReq;
    mIds.delete();
    resQ.delete();
    sb.delete();
    mPtr = 0;
    mErr = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy_o), 128'(0));
    checkOutput("rst_err", 128'(err_o), 128'(0));
    checkOutput("rst_apu_req", 128'(apu_req_o), 128'(0));
    checkOutput("rst_core_valid", 128'(core_valid_o), 128'(0));
    checkOutput("rst_apu_operands", 128'(apu_operands_o), 128'(0));
    @(negedge clk);
    rst_n       = 1'b1;
    apu_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((mIds.size() != 0 || pendReq != '0) && guard < 64) begin
      applyStimulus('0, 1'b1, 1'b1, 1'b0);
      guard++;
    end
    if (guard == 64) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL drain: outstanding=%0d pending=%0h, expected none", mIds.size(), pendReq);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expected response.
  initial begin
    sbEntry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (core_valid_o != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 128'(core_valid_o), 128'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("valid_core", 128'(core_valid_o), 128'(N'(1) << e.id));
          checkOutput("valid_result", 128'(core_result_o), 128'(e.res));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    core_req_i      = '0;
    core_operands_i = '0;
    apu_gnt_i       = 1'b0;
    apu_valid_i     = 1'b0;
    apu_result_i    = '0;
    mPtr            = 0;
    mErr            = 1'b0;
    for (int i = 0; i < N; i++) ops[i] = {$urandom, $urandom, $urandom};
    pendReq = '1;
    doReset();

    $display("[TB] all cores request, responses three cycles later");
    for (int c = 0; c < 8; c++) begin
      applyStimulus((c == 0) ? N'(4'hF) : ((c == 1) ? N'(4'h1) : N'(0)), 1'b1, c >= 3, 1'b0);
    end
    drain();

    $display("[TB] core 2 alone, delayed grant");
    applyStimulus(N'(4'b0100), 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    applyStimulus(N'(4'hF), 1'b1, 1'b0, 1'b0);
    drain();

    $display("[TB] full queue blocks requests");
    repeat (4) applyStimulus(N'(4'hF), 1'b1, 1'b0, 1'b0);
    applyStimulus(N'(4'hF), 1'b1, 1'b0, 1'b0);
    applyStimulus(N'(4'hF), 1'b1, 1'b1, 1'b0);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    drain();

    $display("[TB] zero-latency bypass");
    applyStimulus(N'(4'b0010), 1'b1, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);

    $display("[TB] orphan response sets sticky error");
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    doReset();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset with outstanding requests");
    repeat (3) applyStimulus(N'(4'b0111), 1'b1, 1'b0, 1'b0);
    doReset();
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    applyStimulus(N'(4'hF), 1'b1, 1'b0, 1'b0);
    drain();

    $display("[TB] randomized traffic");
    repeat (400) begin
      applyStimulus(N'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end
    drain();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/riscv_apu_arbiter.md
RISCV_APU_ARBITER -- requirements
Module: riscv_apu_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_CORES, default 4, number of requesting cores (2..8).
- WOP, default 96, width of the operand bundle.
- WRES, default 32, width of the result.
- DEPTH, default 4, maximum number of outstanding requests (power of 2).
REQ-002 clk_i  in  1  single clock; all state on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 core_req_i  in  NUM_CORES  per-core request.
REQ-005 core_operands_i  in  NUM_CORES x WOP  per-core operand bundle.
REQ-006 core_gnt_o  out  NUM_CORES  per-core grant, one-hot or zero.
REQ-007 core_valid_o  out  NUM_CORES  per-core response strobe, one-hot or zero.
REQ-008 core_result_o  out  WRES  result, broadcast to all cores.
REQ-009 apu_req_o  out  1  request to the shared APU.
REQ-010 apu_operands_o  out  WOP  operands of the winning core.
REQ-011 apu_gnt_i  in  1  APU accepts the request.
REQ-012 apu_valid_i  in  1  APU result valid; APU results return in acceptance order.
REQ-013 apu_result_i  in  WRES  APU result.
REQ-014 busy_o  out  1  at least one request is outstanding.
REQ-015 err_o  out  1  sticky error flag: response arrived with no request outstanding.

Function
REQ-016 Handshake: an accepted request is core_req_i[w] & core_gnt_o[w]; a core SHALL hold its req and operands stable until granted, and the block relies on this.
REQ-017 Arbitration SHALL be round-robin, combinational:
- The winner w is the first requesting core at or after pointer ptr, searching upward and wrapping modulo NUM_CORES.
REQ-018 apu_req_o SHALL equal (|core_req_i) & (count != DEPTH).
- A simultaneous pop SHALL NOT unblock a full queue in the same cycle.
REQ-019 apu_operands_o SHALL equal core_operands_i[w] whenever apu_req_o=1; it SHALL be 0 otherwise.
REQ-020 core_gnt_o[w] SHALL equal apu_req_o & apu_gnt_i; all other grant bits SHALL be 0.
REQ-021 On each accepted handshake, ptr SHALL become (w+1) mod NUM_CORES on the next edge; otherwise ptr SHALL hold.
REQ-022 ID queue: a FIFO of DEPTH entries, each holding a core index, with a count of 0..DEPTH.
- Push w on an accepted handshake.
- Pop the head when apu_valid_i=1 and count != 0.
REQ-023 Response routing, count != 0: core_valid_o[head] = apu_valid_i, combinationally in the same cycle.
REQ-024 Bypass, count=0: if apu_valid_i=1 and a handshake is accepted in the same cycle:
- core_valid_o[w] SHALL be 1.
- No push SHALL occur (zero-latency result).
REQ-025 If apu_valid_i=1 with count=0 and no handshake:
- core_valid_o SHALL be all zero.
- err_o SHALL be set and stay set until reset.
REQ-026 core_result_o SHALL equal apu_result_i at all times; it is qualified only by core_valid_o.
REQ-027 Simultaneous push and pop with count below DEPTH SHALL leave count unchanged and shall correctly enqueue both.
REQ-028 The read and write pointers SHALL wrap modulo DEPTH.
REQ-029 busy_o SHALL equal (count != 0).
REQ-030 No combinational path SHALL exist from apu_valid_i to apu_req_o.

Reset
REQ-031 When rst_ni is asserted, asynchronously:
- ptr=0, count=0, FIFO pointers=0, err_o=0.
- Outstanding requests SHALL be discarded.
- Responses arriving after reset SHALL be treated per REQ-025.
REQ-032 During reset, all outputs SHALL be 0, except apu_operands_o and core_result_o, which follow REQ-019 and REQ-026.

Verification
REQ-033 All four cores request at once, apu_gnt_i=1 constantly, responses 3 cycles later -> grants in order 0,1,2,3,0; each core_valid_o pulses exactly once per grant, in grant order.
REQ-034 Core 2 only, with apu_gnt_i=0 for 2 cycles, then 1 -> core_gnt_o[2] high only in cycle 3; ptr=3 afterwards.
REQ-035 DEPTH=4, four accepted requests and no responses -> apu_req_o=0 while count=4; a pop re-enables apu_req_o one cycle later.
REQ-036 count=0, core 1 requests, apu_gnt_i and apu_valid_i both high in the same cycle -> core_valid_o=4'b0010 in that cycle; busy_o stays 0.
REQ-037 count=0, apu_valid_i=1 with no request -> err_o=1 from the next cycle onward; rst_ni low clears it.
REQ-038 Reset asserted with count=3 -> busy_o=0 and ptr=0 immediately; no core_valid_o for the stale entries.
